// File: rtl/regfile_scoreboard_if.sv
// Bus between the issue/writeback pipeline and the register file scoreboard.
// The pipeline drives the master side; the scoreboard sits on the slave side.
interface regfile_scoreboard_if #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32
);
  logic              wb_we;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic [IDX_W-1:0]  rs0_idx;
  logic [IDX_W-1:0]  rs1_idx;
  logic [DATA_W-1:0] rs0_data;
  logic [DATA_W-1:0] rs1_data;
  logic              rs0_busy;
  logic              rs1_busy;
  logic              issue_valid;
  logic              issue_wr;
  logic [IDX_W-1:0]  issue_rd;
  logic              issue_ready;
  logic              flush;
  logic              err_underflow;

  modport master (
    output wb_we, wb_idx, wb_data, rs0_idx, rs1_idx,
    output issue_valid, issue_wr, issue_rd, flush,
    input  rs0_data, rs1_data, rs0_busy, rs1_busy, issue_ready, err_underflow
  );

  modport slave (
    input  wb_we, wb_idx, wb_data, rs0_idx, rs1_idx,
    input  issue_valid, issue_wr, issue_rd, flush,
    output rs0_data, rs1_data, rs0_busy, rs1_busy, issue_ready, err_underflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file with two bypassed read ports and a per-register
// pending-write counter used by issue to detect RAW hazards.
module regfile_scoreboard #(
  parameter int NR_REG = 32,
  parameter int PEND_W = 2,
  parameter bit BYPASS = 1'b1
) (
  input logic                clk,
  input logic                rst,
  regfile_scoreboard_if.slave bus
);
  localparam int              IDX_W   = $clog2(NR_REG);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [31:0]       regs_q [NR_REG];
  logic [PEND_W-1:0] cnt_q  [NR_REG];
  logic [PEND_W-1:0] cnt_d  [NR_REG];
  logic              err_q, err_d;

  logic wb_hit, dec, inc, underflow, issue_ready;

  assign wb_hit = bus.wb_we && (bus.wb_idx != '0);
  assign dec    = wb_hit && (cnt_q[bus.wb_idx] != '0);

  // A saturated destination can still accept a mark if a writer retires this cycle.
  assign issue_ready = !(bus.issue_valid && bus.issue_wr && (bus.issue_rd != '0) &&
                         (cnt_q[bus.issue_rd] == CNT_MAX) &&
                         !(dec && (bus.wb_idx == bus.issue_rd)));
  assign inc       = bus.issue_valid && bus.issue_wr && (bus.issue_rd != '0) && issue_ready;
  assign underflow = wb_hit && (cnt_q[bus.wb_idx] == '0) &&
                     !(inc && (bus.issue_rd == bus.wb_idx));
  assign err_d     = err_q | underflow;

  function automatic logic [31:0] read_data(input logic [IDX_W-1:0] idx);
    if (idx == '0)                                   return '0;
    else if (BYPASS && bus.wb_we && bus.wb_idx == idx) return bus.wb_data;
    else                                             return regs_q[idx];
  endfunction

  function automatic logic read_busy(input logic [IDX_W-1:0] idx);
    return (cnt_q[idx] != '0) &&
           !(BYPASS && bus.wb_we && (bus.wb_idx == idx) && (cnt_q[idx] == PEND_W'(1)));
  endfunction

  assign bus.rs0_data      = read_data(bus.rs0_idx);
  assign bus.rs1_data      = read_data(bus.rs1_idx);
  assign bus.rs0_busy      = read_busy(bus.rs0_idx);
  assign bus.rs1_busy      = read_busy(bus.rs1_idx);
  assign bus.issue_ready   = issue_ready;
  assign bus.err_underflow = err_q;

  always_comb begin
    for (int i = 0; i < NR_REG; i++) begin
      // NOTE: every path starts from a default so no latch is inferred.
      cnt_d[i] = cnt_q[i];
      if (bus.flush) begin
        cnt_d[i] = '0;
      end else if (inc && bus.issue_rd == IDX_W'(i) && !(dec && bus.wb_idx == IDX_W'(i))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && bus.wb_idx == IDX_W'(i) && !(inc && bus.issue_rd == IDX_W'(i))) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is reset explicitly because reset must clear architectural state.
      for (int i = 0; i < NR_REG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (wb_hit) regs_q[bus.wb_idx] <= bus.wb_data;
      for (int i = 0; i < NR_REG; i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector table, a flush-priority sequence, and a randomized run
// compared against a counting model of the register file and scoreboard.
module tb_regfile_scoreboard;
  localparam int PMAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.IDX_W(5), .DATA_W(32)) bus ();

  regfile_scoreboard #(.NR_REG(32), .PEND_W(2), .BYPASS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int rst, we, widx, wdata, rs0, rs1, iv, iw, ird, fl;
    int d0, b0, d1, b1, rdy, err;
  } vec_t;

  vec_t vecs [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input int we, input int widx, input int wdata,
                       input int r0, input int r1, input int iv, input int iw,
                       input int ird, input int fl);
    rst             = (r != 0);
    bus.wb_we       = (we != 0);
    bus.wb_idx      = 5'(widx);
    bus.wb_data     = 32'(wdata);
    bus.rs0_idx     = 5'(r0);
    bus.rs1_idx     = 5'(r1);
    bus.issue_valid = (iv != 0);
    bus.issue_wr    = (iw != 0);
    bus.issue_rd    = 5'(ird);
    bus.flush       = (fl != 0);
  endtask

  task automatic expect_all(input string tag, input int d0, input int b0, input int d1,
                            input int b1, input int rdy, input int err);
    check({tag, " rs0_data"}, bus.rs0_data, 32'(d0));
    check({tag, " rs0_busy"}, 32'(bus.rs0_busy), 32'(b0));
    check({tag, " rs1_data"}, bus.rs1_data, 32'(d1));
    check({tag, " rs1_busy"}, 32'(bus.rs1_busy), 32'(b1));
    check({tag, " issue_ready"}, 32'(bus.issue_ready), 32'(rdy));
    check({tag, " err_underflow"}, 32'(bus.err_underflow), 32'(err));
  endtask

  // Reference model: stored values, in-flight write counts, sticky error.
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_err;

  initial begin
    //          rst we widx wdata         rs0 rs1 iv iw ird fl   d0            b0 d1            b1 rdy err
    vecs[0]  = '{0, 0, 0,  0,            5,  0,  0, 0, 0,  0,   0,            0, 0,            0, 1,  0};
    vecs[1]  = '{0, 0, 0,  0,            5,  0,  1, 1, 5,  0,   0,            0, 0,            0, 1,  0};
    vecs[2]  = '{0, 0, 0,  0,            5,  0,  0, 0, 0,  0,   0,            1, 0,            0, 1,  0};
    vecs[3]  = '{0, 1, 5,  32'hDEADBEEF, 5,  5,  0, 0, 0,  0,   32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1,  0};
    vecs[4]  = '{0, 0, 0,  0,            5,  0,  0, 0, 0,  0,   32'hDEADBEEF, 0, 0,            0, 1,  0};
    vecs[5]  = '{0, 0, 0,  0,            7,  5,  1, 1, 7,  0,   0,            0, 32'hDEADBEEF, 0, 1,  0};
    vecs[6]  = '{0, 0, 0,  0,            7,  5,  1, 1, 7,  0,   0,            1, 32'hDEADBEEF, 0, 1,  0};
    vecs[7]  = '{0, 0, 0,  0,            7,  5,  1, 1, 7,  0,   0,            1, 32'hDEADBEEF, 0, 1,  0};
    vecs[8]  = '{0, 0, 0,  0,            7,  5,  1, 1, 7,  0,   0,            1, 32'hDEADBEEF, 0, 0,  0};
    vecs[9]  = '{0, 1, 7,  32'h77,       7,  5,  1, 1, 7,  0,   32'h77,       1, 32'hDEADBEEF, 0, 1,  0};
    vecs[10] = '{0, 0, 0,  0,            7,  5,  1, 1, 7,  0,   32'h77,       1, 32'hDEADBEEF, 0, 0,  0};
    vecs[11] = '{0, 1, 7,  1,            7,  0,  0, 0, 0,  0,   1,            1, 0,            0, 1,  0};
    vecs[12] = '{0, 1, 7,  2,            7,  0,  0, 0, 0,  0,   2,            1, 0,            0, 1,  0};
    vecs[13] = '{0, 1, 7,  3,            7,  0,  0, 0, 0,  0,   3,            0, 0,            0, 1,  0};
    vecs[14] = '{0, 0, 0,  0,            7,  0,  0, 0, 0,  0,   3,            0, 0,            0, 1,  0};
    vecs[15] = '{0, 1, 0,  32'h1234,     0,  0,  1, 1, 0,  0,   0,            0, 0,            0, 1,  0};
    vecs[16] = '{0, 0, 0,  0,            0,  0,  0, 0, 0,  0,   0,            0, 0,            0, 1,  0};
    vecs[17] = '{0, 0, 0,  0,            3,  4,  1, 1, 3,  0,   0,            0, 0,            0, 1,  0};
    vecs[18] = '{0, 0, 0,  0,            3,  4,  1, 1, 4,  0,   0,            1, 0,            0, 1,  0};
    vecs[19] = '{0, 0, 0,  0,            3,  4,  1, 1, 9,  0,   0,            1, 0,            1, 1,  0};
    vecs[20] = '{0, 1, 9,  32'h55,       3,  4,  0, 0, 0,  1,   0,            1, 0,            1, 1,  0};
    vecs[21] = '{0, 0, 0,  0,            3,  4,  0, 0, 0,  0,   0,            0, 0,            0, 1,  0};
    vecs[22] = '{0, 0, 0,  0,            9,  9,  0, 0, 0,  0,   32'h55,       0, 32'h55,       0, 1,  0};
    vecs[23] = '{0, 1, 10, 32'hA5A5,     10, 0,  0, 0, 0,  0,   32'hA5A5,     0, 0,            0, 1,  0};
    vecs[24] = '{0, 0, 0,  0,            10, 5,  0, 0, 0,  0,   32'hA5A5,     0, 32'hDEADBEEF, 0, 1,  1};
    vecs[25] = '{1, 1, 11, 32'hFF,       10, 11, 0, 0, 0,  0,   32'hA5A5,     0, 32'hFF,       0, 1,  1};
    vecs[26] = '{0, 0, 0,  0,            10, 11, 0, 0, 0,  0,   0,            0, 0,            0, 1,  0};

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].we, vecs[i].widx, vecs[i].wdata, vecs[i].rs0, vecs[i].rs1,
            vecs[i].iv, vecs[i].iw, vecs[i].ird, vecs[i].fl);
      #1;
      expect_all($sformatf("vec%0d", i), vecs[i].d0, vecs[i].b0, vecs[i].d1,
                 vecs[i].b1, vecs[i].rdy, vecs[i].err);
    end

    // Flush wins over a same-cycle mark; a writeback after flush underflows.
    @(negedge clk); drive(0, 0, 0, 0, 12, 0, 1, 1, 12, 1); #1;
    check("flush+issue ready", 32'(bus.issue_ready), 32'd1);
    @(negedge clk); drive(0, 0, 0, 0, 12, 0, 1, 1, 12, 0); #1;
    check("flush priority busy", 32'(bus.rs0_busy), 32'd0);
    @(negedge clk); drive(0, 0, 0, 0, 12, 0, 0, 0, 0, 1); #1;
    check("mark after flush busy", 32'(bus.rs0_busy), 32'd1);
    check("mark after flush err", 32'(bus.err_underflow), 32'd0);
    @(negedge clk); drive(0, 1, 12, 32'h1200, 12, 0, 0, 0, 0, 0); #1;
    check("post-flush wb busy", 32'(bus.rs0_busy), 32'd0);
    check("post-flush wb bypass", bus.rs0_data, 32'h1200);
    @(negedge clk); drive(0, 0, 0, 0, 12, 0, 0, 0, 0, 0); #1;
    check("post-flush underflow", 32'(bus.err_underflow), 32'd1);
    check("post-flush stored", bus.rs0_data, 32'h1200);

    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;

    for (int c = 0; c < 400; c++) begin
      int r, we, widx, wdata, r0, r1, iv, iw, ird, fl;
      bit retire, rdy, accept;
      logic [31:0] e0, e1;
      bit b0, b1;
      @(negedge clk);
      r     = ($urandom_range(63) == 0) ? 1 : 0;
      we    = int'($urandom_range(1));
      widx  = int'($urandom_range(7));
      wdata = int'($urandom);
      r0    = int'($urandom_range(7));
      r1    = int'($urandom_range(7));
      iv    = int'($urandom_range(1));
      iw    = ($urandom_range(3) != 0) ? 1 : 0;
      ird   = int'($urandom_range(7));
      fl    = ($urandom_range(15) == 0) ? 1 : 0;
      drive(r, we, widx, wdata, r0, r1, iv, iw, ird, fl);

      retire = (we != 0) && (widx != 0) && (m_cnt[widx] > 0);
      rdy    = !((iv != 0) && (iw != 0) && (ird != 0) && (m_cnt[ird] == PMAX) &&
                 !(retire && widx == ird));
      e0 = (r0 == 0) ? 32'd0 : ((we != 0 && widx == r0) ? 32'(wdata) : m_reg[r0]);
      e1 = (r1 == 0) ? 32'd0 : ((we != 0 && widx == r1) ? 32'(wdata) : m_reg[r1]);
      b0 = (m_cnt[r0] > 0) && !(we != 0 && widx == r0 && m_cnt[r0] == 1);
      b1 = (m_cnt[r1] > 0) && !(we != 0 && widx == r1 && m_cnt[r1] == 1);
      #1;
      expect_all($sformatf("rnd%0d", c), int'(e0), int'(b0), int'(e1), int'(b1),
                 int'(rdy), int'(m_err));

      accept = (iv != 0) && (iw != 0) && (ird != 0) && rdy;
      if (r != 0) begin
        for (int i = 0; i < 32; i++) begin
          m_reg[i] = '0;
          m_cnt[i] = 0;
        end
        m_err = 1'b0;
      end else begin
        if (we != 0 && widx != 0) begin
          m_reg[widx] = 32'(wdata);
          if (m_cnt[widx] == 0 && !(accept && ird == widx)) m_err = 1'b1;
        end
        if (fl != 0) begin
          for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
          if (accept) m_cnt[ird] = m_cnt[ird] + 1;
          if (retire) m_cnt[widx] = m_cnt[widx] - 1;
        end
      end
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
